// File: rtl/acc_seq_decode.sv
// rtl/acc_seq_decode.sv - instruction decode and MCT/timepulse sequencer
//
// Takes one 15-bit instruction word from the instruction register and splits it
// into a 3-bit order code and a 12-bit address. It then runs the word through its
// memory cycle times (MCTs). Each MCT is NTP timepulses long. The sequencer exposes
// the timing state so that later execute stages can use it.
//
// Ports:
//   clk          system clock, all flops on posedge
//   rstn         asynchronous active-low reset
//   instr        instruction word ([14:12] order code, [11:0] address)
//   instr_valid  instr holds a word ready for execution
//   instr_ready  sequencer can accept a word (IDLE and out of reset)
//   step         timepulse advance enable, sampled every clk
//   opcode       latched order code, stable until the next accept
//   addr         latched address field, stable until the next accept
//   tp           current timepulse 1..NTP, 0 when idle
//   mct          current MCT index 1..2, 0 when idle
//   mct_end      1-cycle pulse after the final advance of each MCT
//   busy         an instruction is executing
//   done         1-cycle pulse when an instruction completes

module acc_seq_decode #(
  parameter int IW  = 15,
  parameter int NTP = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          step,
  output logic [2:0]    opcode,
  output logic [11:0]   addr,
  output logic [3:0]    tp,
  output logic [1:0]    mct,
  output logic          mct_end,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [3:0] TP_LAST = 4'(NTP);

  state_t      state_q, state_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  tp_q, tp_d;
  logic [1:0]  mct_q, mct_d;
  logic        mct_end_q, mct_end_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        last_tp;
  logic        last_mct;
  logic [1:0]  mct_count;

  // TC needs only one MCT. Every other order code needs two.
  assign mct_count = (opcode_q == 3'd0) ? 2'd1 : 2'd2;
  assign accept    = instr_valid & instr_ready;
  assign last_tp   = (tp_q == TP_LAST);
  assign last_mct  = (mct_q >= mct_count);

  // State register. The datapath flops share the same asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      opcode_q  <= 3'd0;
      addr_q    <= 12'd0;
      tp_q      <= 4'd0;
      mct_q     <= 2'd0;
      mct_end_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      tp_q      <= tp_d;
      mct_q     <= mct_d;
      mct_end_q <= mct_end_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic for the FSM and the timing counters.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    addr_d    = addr_q;
    tp_d      = tp_q;
    mct_d     = mct_q;
    busy_d    = busy_q;
    mct_end_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EXEC;
          opcode_d = instr[14:12];
          addr_d   = instr[11:0];
          tp_d     = 4'd1;
          mct_d    = 2'd1;
          busy_d   = 1'b1;
        end
      end
      EXEC: begin
        if (step) begin
          if (!last_tp) begin
            tp_d = tp_q + 4'd1;
          end else begin
            mct_end_d = 1'b1;
            if (!last_mct) begin
              mct_d = mct_q + 2'd1;
              tp_d  = 4'd1;
            end else begin
              state_d = IDLE;
              tp_d    = 4'd0;
              mct_d   = 2'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. instr_ready is gated by rstn so that it reads low while reset is held.
  always_comb begin
    instr_ready = (state_q == IDLE) & rstn;
    opcode      = opcode_q;
    addr        = addr_q;
    tp          = tp_q;
    mct         = mct_q;
    mct_end     = mct_end_q;
    busy        = busy_q;
    done        = done_q;
  end

endmodule

// File: tb/tb_acc_seq_decode.sv
// tb/tb_acc_seq_decode.sv - scoreboard bench for acc_seq_decode

module tb_acc_seq_decode;

  logic        clk = 1'b0;
  logic        rstn;
  logic [14:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        step;
  logic [2:0]  opcode;
  logic [11:0] addr;
  logic [3:0]  tp;
  logic [1:0]  mct;
  logic        mct_end;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  // Words the stimulus has offered, waiting to be accepted.
  logic [14:0] exp_q[$];

  // Reference model state: the instruction in flight and the number of timepulse
  // advances made so far.
  bit          m_busy = 0;
  int          m_k    = 0;
  int          m_n    = 0;
  logic [2:0]  m_op   = 3'd0;
  logic [11:0] m_addr = 12'd0;
  bit          m_done = 0;
  bit          m_end  = 0;

  acc_seq_decode #(.IW(15), .NTP(12)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .step        (step),
    .opcode      (opcode),
    .addr        (addr),
    .tp          (tp),
    .mct         (mct),
    .mct_end     (mct_end),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: runs on negedge. It compares the outputs with the model and then
  // applies the inputs that the next posedge will sample.
  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_outputs", int'({opcode, addr, tp, mct, mct_end, busy, done}), 0);
      check("rst_ready", int'(instr_ready), 0);
      m_busy = 0; m_k = 0; m_done = 0; m_end = 0; m_op = 3'd0; m_addr = 12'd0;
    end else begin
      check("tp", int'(tp), m_busy ? (m_k % 12) + 1 : 0);
      check("mct", int'(mct), m_busy ? (m_k / 12) + 1 : 0);
      check("busy", int'(busy), int'(m_busy));
      check("ready", int'(instr_ready), int'(!m_busy));
      check("done", int'(done), int'(m_done));
      check("mct_end", int'(mct_end), int'(m_end));
      check("opcode", int'(opcode), int'(m_op));
      check("addr", int'(addr), int'(m_addr));
      m_done = 0;
      m_end  = 0;
      if (m_busy) begin
        if (step) begin
          if (m_k % 12 == 11) m_end = 1;
          m_k++;
          if (m_k == 12 * m_n) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 1, 0);
        end else begin
          logic [14:0] w;
          w = exp_q.pop_front();
          m_op   = w[14:12];
          m_addr = w[11:0];
          m_n    = (w[14:12] == 3'd0) ? 1 : 2;
          m_k    = 0;
          m_busy = 1;
        end
      end
    end
  end

  // Offer a word and return once it has been accepted (posedge+1 of the accept edge).
  task automatic offer(input logic [14:0] w);
    int guard;
    exp_q.push_back(w);
    instr = w;
    instr_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!instr_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("accept_timeout", guard, 0);
    @(posedge clk); #1;
  endtask

  // Count cycles from the accept edge up to the done pulse and compare with lat.
  task automatic wait_done(input string name, input int lat);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 200);
    check(name, c, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    instr = 15'h0805;
    instr_valid = 1'b1;
    step = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_direct", int'(instr_ready), 0);

    // TC word: offered while in reset and accepted at the first posedge after release.
    exp_q.push_back(15'h0805);
    rstn = 1'b1;
    #1;
    check("ready_after_release", int'(instr_ready), 1);
    check("no_accept_before_edge", int'(busy), 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done("tc_latency", 13);

    // AD word
    offer(15'h6123);
    instr_valid = 1'b0;
    wait_done("ad_latency", 25);

    // Back-to-back: valid stays high and TC is taken in the XCH done cycle.
    offer(15'h3010);
    offer(15'h0000);
    instr_valid = 1'b0;
    wait_done("b2b_tc_latency", 13);

    // Single-step TS with a step pulse every 5th cycle. The last pulses land in IDLE.
    step = 1'b0;
    offer(15'h5007);
    instr_valid = 1'b0;
    for (int p = 0; p < 30; p++) begin
      repeat (4) @(posedge clk);
      #1 step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("ss_idle_tp", int'(tp), 0);

    // Random words run free, with occasional held-low step cycles.
    for (int r = 0; r < 6; r++) begin
      step = 1'b1;
      offer(15'($urandom));
      instr_valid = 1'b0;
      for (int c = 0; c < 30 && (busy || done); c++) begin
        step = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      step = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end

    // Reset in the middle of the second MCT of a CS word.
    offer(15'h4001);
    instr_valid = 1'b0;
    begin
      int g;
      g = 0;
      @(negedge clk);
      while (!(mct == 2'd2 && tp == 4'd7) && g < 100) begin
        g++;
        @(negedge clk);
      end
      check("reach_mct2_tp7", g < 100 ? 1 : 0, 1);
    end
    #1 rstn = 1'b0;
    #1;
    check("async_rst_outputs", int'({opcode, addr, tp, mct, mct_end, busy, done}), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    offer(15'h1abc);
    instr_valid = 1'b0;
    wait_done("post_rst_latency", 25);
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
